seq_det_ctrl: RTL and testbench

Session controller for the serial pattern detector. Holds a programmable pattern of up to MAXLEN bits and arms/disarms a detection session on command. Counts overlapping matches on a qualified serial stream and ends the session on a target match count, a cycle timeout, or an abort. Sits between the register/control interface and the serial input path; det_o keeps the existing detector's single-pulse-per-match semantics.

---
 rtl/seq_det_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Session controller for the serial pattern detector: programmable pattern,
// overlapping match counting, and session end on target count, timeout or abort.
module seq_det_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8,
  parameter int TMO_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [MAXLEN-1:0]       cfg_pattern,
  input  logic [$clog2(MAXLEN):0] cfg_len,
  input  logic [CNT_W-1:0]        cfg_target,
  input  logic [TMO_W-1:0]        cfg_timeout,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    seq_in,
  input  logic                    seq_valid,
  output logic                    busy,
  output logic                    det_o,
  output logic [CNT_W-1:0]        match_cnt,
  output logic                    done,
  output logic                    timed_out,
  output logic [1:0]              state_o
);

  localparam int LEN_W = $clog2(MAXLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [MAXLEN-1:0]   sr_q, sr_d;
  logic [LEN_W-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                to_q, to_d;
  logic                det_q, det_d;
  logic [MAXLEN-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    tgt_q, tgt_d;
  logic [TMO_W-1:0]    tmo_cfg_q, tmo_cfg_d;

  logic [MAXLEN-1:0]   sr_shift_s;
  logic [MAXLEN-1:0]   mask_s;
  logic [LEN_W-1:0]    fill_inc_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic                match_s;
  logic                tmo_last_s;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      to_q      <= 1'b0;
      det_q     <= 1'b0;
      pat_q     <= MAXLEN'(4'b1010);
      len_q     <= LEN_W'(4);
      tgt_q     <= '0;
      tmo_cfg_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      to_q      <= to_d;
      det_q     <= det_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      tgt_q     <= tgt_d;
      tmo_cfg_q <= tmo_cfg_d;
    end
  end

  // Next-state, match detection and session bookkeeping
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    to_d      = to_q;
    det_d     = 1'b0;
    pat_d     = pat_q;
    len_d     = len_q;
    tgt_d     = tgt_q;
    tmo_cfg_d = tmo_cfg_q;

    sr_shift_s = {sr_q[MAXLEN-2:0], seq_in};
    fill_inc_s = (fill_q == LEN_W'(MAXLEN)) ? fill_q : fill_q + LEN_W'(1);
    cnt_inc_s  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    for (int i = 0; i < MAXLEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end
    // The freshly shifted value is compared, so a match fires on the edge that samples its last bit
    match_s    = seq_valid && (fill_inc_s >= len_q) &&
                 ((sr_shift_s & mask_s) == (pat_q & mask_s));
    tmo_last_s = (tmo_cfg_q != '0) && (tmo_q == tmo_cfg_q - TMO_W'(1));

    if (cfg_we && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      pat_d     = cfg_pattern;
      tgt_d     = cfg_target;
      tmo_cfg_d = cfg_timeout;
      if (cfg_len == '0) begin
        len_d = LEN_W'(1);
      end else if (cfg_len > LEN_W'(MAXLEN)) begin
        len_d = LEN_W'(MAXLEN);
      end else begin
        len_d = cfg_len;
      end
    end else begin
      len_d = len_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_ARM;
        end else begin
          state_d = state_q;
        end
      end
      S_ARM: begin
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (seq_valid) begin
            sr_d   = sr_shift_s;
            fill_d = fill_inc_s;
          end else begin
            sr_d   = sr_q;
            fill_d = fill_q;
          end
          if (match_s) begin
            det_d = 1'b1;
            cnt_d = cnt_inc_s;
          end else begin
            det_d = 1'b0;
            cnt_d = cnt_q;
          end
          // A terminating match beats a coincident timeout
          if (match_s && (tgt_q != '0) && (cnt_inc_s == tgt_q)) begin
            state_d = S_DONE;
            to_d    = 1'b0;
          end else if (tmo_last_s) begin
            state_d = S_DONE;
            to_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Session state is cleared on the edge that enters ARM
    if ((state_d == S_ARM) && (state_q != S_ARM)) begin
      sr_d   = '0;
      fill_d = '0;
      cnt_d  = '0;
      tmo_d  = '0;
      to_d   = 1'b0;
    end else begin
      to_d = to_d;
    end
  end

  assign busy      = (state_q == S_ARM) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign state_o   = state_q;
  assign det_o     = det_q;
  assign match_cnt = cnt_q;
  assign timed_out = to_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus randomized
// stimulus, all compared against a bit-history reference model every cycle.
module tb_seq_det_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_pattern = 8'd0;
  logic [3:0]  cfg_len = 4'd0;
  logic [7:0]  cfg_target = 8'd0;
  logic [15:0] cfg_timeout = 16'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        seq_in = 1'b0;
  logic        seq_valid = 1'b0;
  logic        busy, det_o, done, timed_out;
  logic [7:0]  match_cnt;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: sessions as a history of received bits
  int         m_state, m_cnt, m_len, m_tgt, m_tmo, m_run;
  bit         m_to, m_det;
  logic [7:0] m_pat;
  bit         hist[$];

  seq_det_ctrl #(.MAXLEN(8), .CNT_W(8), .TMO_W(16)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
    .start(start), .abort(abort), .seq_in(seq_in), .seq_valid(seq_valid),
    .busy(busy), .det_o(det_o), .match_cnt(match_cnt), .done(done),
    .timed_out(timed_out), .state_o(state_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_match();
    int n;
    n = hist.size();
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (hist[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_edge();
    int nst;
    bit fin;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_to = 1'b0; m_det = 1'b0; m_run = 0;
      m_pat = 8'b0000_1010; m_len = 4; m_tgt = 0; m_tmo = 0;
      hist.delete();
      return;
    end
    nst = m_state;
    fin = 1'b0;
    m_det = 1'b0;
    if (cfg_we && (m_state == 0 || m_state == 3)) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 4'd0) ? 1 : ((int'(cfg_len) > 8) ? 8 : int'(cfg_len));
      m_tgt = int'(cfg_target);
      m_tmo = int'(cfg_timeout);
    end
    case (m_state)
      0, 3: begin
        if (abort) nst = 0;
        else if (start) begin
          nst = 1; m_cnt = 0; m_to = 1'b0; m_run = 0;
          hist.delete();
        end
      end
      1: nst = abort ? 0 : 2;
      2: begin
        if (abort) nst = 0;
        else begin
          m_run++;
          if (seq_valid) begin
            hist.push_back(seq_in);
            if (hist.size() > 16) void'(hist.pop_front());
            if (model_match()) begin
              m_det = 1'b1;
              if (m_cnt < 255) m_cnt++;
              if (m_tgt != 0 && m_cnt == m_tgt) begin
                nst = 3; m_to = 1'b0; fin = 1'b1;
              end
            end
          end
          if (!fin && m_tmo != 0 && m_run == m_tmo) begin
            nst = 3; m_to = 1'b1;
          end
        end
      end
      default: nst = 0;
    endcase
    m_state = nst;
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("state", state_o, m_state);
    chk("busy", busy, (m_state == 1 || m_state == 2) ? 1 : 0);
    chk("done", done, (m_state == 3) ? 1 : 0);
    chk("det", det_o, m_det);
    chk("cnt", match_cnt, m_cnt);
    chk("timed_out", timed_out, m_to);
  endtask

  task automatic send(input bit b);
    seq_valid = 1'b1; seq_in = b;
    step();
    seq_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l,
                        input logic [7:0] t, input logic [15:0] to);
    cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_timeout = to; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  initial begin
    logic [5:0] e1;
    logic [3:0] e2;
    logic [3:0] bits;

    // Reset and default pattern 1010
    reset = 1'b1; step(); step(); reset = 1'b0;
    chk("rst_state", state_o, 0); chk("rst_cnt", match_cnt, 0);
    do_start();
    chk("t1_run", state_o, 2);
    e1 = 6'b101000; bits = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      send(i[0] ? 1'b0 : 1'b1);
      chk("t1_det", det_o, e1[i]);
    end
    chk("t1_cnt", match_cnt, 2); chk("t1_state", state_o, 2);

    // Pattern 11, target 3
    abort = 1'b1; step(); abort = 1'b0;
    do_cfg(8'b11, 4'd2, 8'd3, 16'd0);
    do_start();
    e2 = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      send(1'b1);
      chk("t2_det", det_o, e2[i]);
    end
    chk("t2_state", state_o, 3); chk("t2_cnt", match_cnt, 3); chk("t2_to", timed_out, 0);
    send(1'b1);
    chk("t2_ignored", det_o, 0);

    // Timeout with all-zero stream
    do_cfg(8'b1010, 4'd4, 8'd0, 16'd10);
    do_start();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("t3_pre", state_o, 2);
      send(1'b0);
    end
    chk("t3_state", state_o, 3); chk("t3_to", timed_out, 1); chk("t3_cnt", match_cnt, 0);

    // Interleaved invalid cycles
    do_cfg(8'b1010, 4'd4, 8'd0, 16'd0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      seq_valid = 1'b0; seq_in = 1'($urandom); step();
      chk("t4_inv", det_o, 0);
      send(bits[3 - i] ? 1'b0 : 1'b1);
      chk("t4_det", det_o, (i == 3) ? 1 : 0);
    end

    // Abort, start+abort, ignored cfg in RUN, reset mid-RUN
    abort = 1'b1; step(); abort = 1'b0;
    chk("t5_idle", state_o, 0); chk("t5_hold", match_cnt, 1);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("t5_sa", state_o, 0);
    do_start();
    do_cfg(8'b0101, 4'd4, 8'd0, 16'd0);
    send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    chk("t5_oldpat", det_o, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_rst_state", state_o, 0); chk("t5_rst_cnt", match_cnt, 0);
    chk("t5_rst_to", timed_out, 0);

    // Target and timeout on the same edge, then restart from DONE
    do_cfg(8'b1010, 4'd4, 8'd1, 16'd4);
    do_start();
    send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    chk("t6_state", state_o, 3); chk("t6_to", timed_out, 0); chk("t6_det", det_o, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("t6_arm", state_o, 1); chk("t6_clr", match_cnt, 0);
    step();
    chk("t6_run", state_o, 2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      abort       = ($urandom_range(0, 59) == 0);
      start       = ($urandom_range(0, 9) == 0);
      cfg_we      = ($urandom_range(0, 14) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
      cfg_target  = 8'($urandom_range(0, 5));
      cfg_timeout = 16'($urandom_range(0, 40));
      seq_valid   = ($urandom_range(0, 3) != 0);
      seq_in      = 1'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
